// File: rtl/check_connect.sv
// Registered Connect-N line checker: finds the first run of CONN equal player cells.
// Optional bad_cell output enabled by defining CHECK_CONNECT_BADCELL_EN.
module check_connect #(
  parameter int  WIDTH = 4,
  parameter int  CONN  = 3,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [2*WIDTH-1:0] cells,
  output logic               out_valid,
  output logic [1:0]         winner,
  output logic [IDX_W-1:0]   p1_start,
  output logic [IDX_W-1:0]   p2_start
`ifdef CHECK_CONNECT_BADCELL_EN
  ,
  output logic               bad_cell
`endif
);

  localparam logic [1:0] CODE_P1 = 2'b01;
  localparam logic [1:0] CODE_P2 = 2'b10;

  logic             out_valid_q;
  logic [1:0]       winner_q, winner_d;
  logic [IDX_W-1:0] p1_start_q, p1_start_d;
  logic [IDX_W-1:0] p2_start_q, p2_start_d;

  // A run counter reaches CONN for the first time exactly at the end of the
  // lowest winning window, so its start is i-CONN+1. CONN > WIDTH never reaches it.
  always_comb begin
    int run1;
    int run2;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    winner_d   = 2'b00;
    p1_start_d = '0;
    p2_start_d = '0;
    run1       = 0;
    run2       = 0;
    for (int i = 0; i < WIDTH; i++) begin
      run1 = (cells[2*i +: 2] == CODE_P1) ? run1 + 1 : 0;
      run2 = (cells[2*i +: 2] == CODE_P2) ? run2 + 1 : 0;
      if (run1 == CONN && !winner_d[0]) begin
        winner_d[0] = 1'b1;
        p1_start_d  = IDX_W'(i - CONN + 1);
      end
      if (run2 == CONN && !winner_d[1]) begin
        winner_d[1] = 1'b1;
        p2_start_d  = IDX_W'(i - CONN + 1);
      end
    end
  end

`ifdef CHECK_CONNECT_BADCELL_EN
  logic bad_cell_q, bad_cell_d;

  always_comb begin
    bad_cell_d = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cells[2*i +: 2] == 2'b11) bad_cell_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bad_cell_q <= 1'b0;
    end else if (in_valid) begin
      bad_cell_q <= bad_cell_d;
    end
  end

  assign bad_cell = bad_cell_q;
`endif

  // Result registers hold their last value while no sample is offered.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
    if (reset) begin
      out_valid_q <= 1'b0;
      winner_q    <= 2'b00;
      p1_start_q  <= '0;
      p2_start_q  <= '0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        winner_q   <= winner_d;
        p1_start_q <= p1_start_d;
        p2_start_q <= p2_start_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign winner    = winner_q;
  assign p1_start  = p1_start_q;
  assign p2_start  = p2_start_q;

endmodule

// File: tb/tb_check_connect.sv
// Directed bench for check_connect over four WIDTH/CONN configurations.
// Define CHECK_CONNECT_BADCELL_EN for both bench and RTL to cover bad_cell.
module tb_check_connect;

  logic clock = 1'b0;
  logic reset;
  logic in_valid;
  logic [7:0]  cells_a;  // WIDTH=4, CONN=3
  logic [11:0] cells_b;  // WIDTH=6, CONN=3
  logic [3:0]  cells_c;  // WIDTH=2, CONN=3
  logic [7:0]  cells_d;  // WIDTH=4, CONN=1

  logic       ov_a, ov_b, ov_c, ov_d;
  logic [1:0] win_a, win_b, win_c, win_d;
  logic [1:0] p1_a, p2_a, p1_d, p2_d;
  logic [2:0] p1_b, p2_b;
  logic [0:0] p1_c, p2_c;
`ifdef CHECK_CONNECT_BADCELL_EN
  logic bad_a, bad_b, bad_c, bad_d;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  check_connect #(.WIDTH(4), .CONN(3)) u_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .cells(cells_a),
    .out_valid(ov_a), .winner(win_a), .p1_start(p1_a), .p2_start(p2_a)
`ifdef CHECK_CONNECT_BADCELL_EN
    , .bad_cell(bad_a)
`endif
  );

  check_connect #(.WIDTH(6), .CONN(3)) u_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .cells(cells_b),
    .out_valid(ov_b), .winner(win_b), .p1_start(p1_b), .p2_start(p2_b)
`ifdef CHECK_CONNECT_BADCELL_EN
    , .bad_cell(bad_b)
`endif
  );

  check_connect #(.WIDTH(2), .CONN(3)) u_c (
    .clock(clock), .reset(reset), .in_valid(in_valid), .cells(cells_c),
    .out_valid(ov_c), .winner(win_c), .p1_start(p1_c), .p2_start(p2_c)
`ifdef CHECK_CONNECT_BADCELL_EN
    , .bad_cell(bad_c)
`endif
  );

  check_connect #(.WIDTH(4), .CONN(1)) u_d (
    .clock(clock), .reset(reset), .in_valid(in_valid), .cells(cells_d),
    .out_valid(ov_d), .winner(win_d), .p1_start(p1_d), .p2_start(p2_d)
`ifdef CHECK_CONNECT_BADCELL_EN
    , .bad_cell(bad_d)
`endif
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1;
    cells_a = 8'h95; cells_b = 12'hA95; cells_c = 4'h5; cells_d = 8'h80;
    tick();
    checks++;
    if ({ov_a, ov_b, ov_c, ov_d} !== 4'b0000) begin
      errors++; $display("FAIL reset_out_valid got %b exp 0000", {ov_a, ov_b, ov_c, ov_d});
    end
    checks++;
    if ({win_a, win_b, win_c, win_d} !== 8'h00) begin
      errors++; $display("FAIL reset_winner got %h exp 00", {win_a, win_b, win_c, win_d});
    end
    checks++;
    if ({p1_a, p2_a, p1_b, p2_b, p1_c, p2_c, p1_d, p2_d} !== 16'h0000) begin
      errors++; $display("FAIL reset_starts got %h exp 0000", {p1_a, p2_a, p1_b, p2_b, p1_c, p2_c, p1_d, p2_d});
    end
`ifdef CHECK_CONNECT_BADCELL_EN
    checks++;
    if ({bad_a, bad_b, bad_c, bad_d} !== 4'b0000) begin
      errors++; $display("FAIL reset_bad_cell got %b exp 0000", {bad_a, bad_b, bad_c, bad_d});
    end
`endif
    reset = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_basic_w4();
    in_valid = 1'b1; cells_a = 8'h95;  // 01,01,01,10
    tick();
    in_valid = 1'b0;
    checks++;
    if ({ov_a, win_a, p1_a, p2_a} !== {1'b1, 2'b01, 2'd0, 2'd0}) begin
      errors++; $display("FAIL w4_95 got ov=%b win=%b p1=%0d p2=%0d exp ov=1 win=01 p1=0 p2=0", ov_a, win_a, p1_a, p2_a);
    end
    tick();
    checks++;
    if (ov_a !== 1'b0) begin
      errors++; $display("FAIL w4_single_valid got %b exp 0", ov_a);
    end
    in_valid = 1'b1; cells_a = 8'h54;  // 00,01,01,01
    tick();
    checks++;
    if ({win_a, p1_a, p2_a} !== {2'b01, 2'd1, 2'd0}) begin
      errors++; $display("FAIL w4_54 got win=%b p1=%0d p2=%0d exp win=01 p1=1 p2=0", win_a, p1_a, p2_a);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; cells_a = 8'hA9;  // 01,10,10,10
    tick();
    checks++;
    if ({ov_a, win_a, p1_a, p2_a} !== {1'b1, 2'b10, 2'd0, 2'd1}) begin
      errors++; $display("FAIL b2b_A9 got ov=%b win=%b p1=%0d p2=%0d exp ov=1 win=10 p1=0 p2=1", ov_a, win_a, p1_a, p2_a);
    end
    cells_a = 8'h45;  // 01,01,00,01 gap
    tick();
    checks++;
    if ({ov_a, win_a, p1_a, p2_a} !== {1'b1, 2'b00, 2'd0, 2'd0}) begin
      errors++; $display("FAIL b2b_45 got ov=%b win=%b p1=%0d p2=%0d exp ov=1 win=00 p1=0 p2=0", ov_a, win_a, p1_a, p2_a);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_w6();
    in_valid = 1'b1; cells_b = 12'hA95;  // 01,01,01,10,10,10
    tick();
    checks++;
    if ({win_b, p1_b, p2_b} !== {2'b11, 3'd0, 3'd3}) begin
      errors++; $display("FAIL w6_A95 got win=%b p1=%0d p2=%0d exp win=11 p1=0 p2=3", win_b, p1_b, p2_b);
    end
    cells_b = 12'h555;  // run of six player-1 cells
    tick();
    checks++;
    if ({win_b, p1_b, p2_b} !== {2'b01, 3'd0, 3'd0}) begin
      errors++; $display("FAIL w6_555 got win=%b p1=%0d p2=%0d exp win=01 p1=0 p2=0", win_b, p1_b, p2_b);
    end
    cells_b = 12'hAAF;  // 11,11,10,10,10,10
    tick();
    checks++;
    if ({win_b, p1_b, p2_b} !== {2'b10, 3'd0, 3'd2}) begin
      errors++; $display("FAIL w6_AAF got win=%b p1=%0d p2=%0d exp win=10 p1=0 p2=2", win_b, p1_b, p2_b);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_conn_bounds();
    in_valid = 1'b1; cells_c = 4'h5; cells_d = 8'h80;
    tick();
    checks++;
    if ({ov_c, win_c, p1_c, p2_c} !== {1'b1, 2'b00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL conn_gt_width got ov=%b win=%b p1=%0d p2=%0d exp ov=1 win=00 p1=0 p2=0", ov_c, win_c, p1_c, p2_c);
    end
    checks++;
    if ({win_d, p1_d, p2_d} !== {2'b10, 2'd0, 2'd3}) begin
      errors++; $display("FAIL conn1_80 got win=%b p1=%0d p2=%0d exp win=10 p1=0 p2=3", win_d, p1_d, p2_d);
    end
    cells_d = 8'h09;  // 01,10,00,00
    tick();
    checks++;
    if ({win_d, p1_d, p2_d} !== {2'b11, 2'd0, 2'd1}) begin
      errors++; $display("FAIL conn1_09 got win=%b p1=%0d p2=%0d exp win=11 p1=0 p2=1", win_d, p1_d, p2_d);
    end
    cells_d = 8'hFC;  // 00,11,11,11
    tick();
    checks++;
    if ({win_d, p1_d, p2_d} !== {2'b00, 2'd0, 2'd0}) begin
      errors++; $display("FAIL conn1_FC got win=%b p1=%0d p2=%0d exp win=00 p1=0 p2=0", win_d, p1_d, p2_d);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bad_cell();
    in_valid = 1'b1; cells_a = 8'hFF;
    tick();
    checks++;
    if (win_a !== 2'b00) begin
      errors++; $display("FAIL bad_FF_winner got %b exp 00", win_a);
    end
`ifdef CHECK_CONNECT_BADCELL_EN
    checks++;
    if (bad_a !== 1'b1) begin
      errors++; $display("FAIL bad_FF_flag got %b exp 1", bad_a);
    end
`endif
    cells_a = 8'h95;
    tick();
    checks++;
    if (win_a !== 2'b01) begin
      errors++; $display("FAIL bad_95_winner got %b exp 01", win_a);
    end
`ifdef CHECK_CONNECT_BADCELL_EN
    checks++;
    if (bad_a !== 1'b0) begin
      errors++; $display("FAIL bad_95_flag got %b exp 0", bad_a);
    end
`endif
    in_valid = 1'b0;
  endtask

  task automatic test_hold_and_reset_priority();
    in_valid = 1'b1; cells_a = 8'h95;
    tick();
    in_valid = 1'b0; cells_a = 8'hA9;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({ov_a, win_a, p1_a, p2_a} !== {1'b0, 2'b01, 2'd0, 2'd0}) begin
        errors++; $display("FAIL hold_%0d got ov=%b win=%b p1=%0d p2=%0d exp ov=0 win=01 p1=0 p2=0", i, ov_a, win_a, p1_a, p2_a);
      end
    end
    cells_b = 12'hAA0;  // 00,00,10,10,10,10 -> p2_start 2 loaded before reset
    in_valid = 1'b1;
    tick();
    checks++;
    if ({win_b, p2_b} !== {2'b10, 3'd2}) begin
      errors++; $display("FAIL pre_reset_w6 got win=%b p2=%0d exp win=10 p2=2", win_b, p2_b);
    end
    reset = 1'b1; cells_a = 8'hA9;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if ({ov_a, win_a, p1_a, p2_a} !== {1'b0, 2'b00, 2'd0, 2'd0}) begin
      errors++; $display("FAIL reset_prio got ov=%b win=%b p1=%0d p2=%0d exp ov=0 win=00 p1=0 p2=0", ov_a, win_a, p1_a, p2_a);
    end
    checks++;
    if ({ov_b, win_b, p2_b} !== {1'b0, 2'b00, 3'd0}) begin
      errors++; $display("FAIL reset_prio_w6 got ov=%b win=%b p2=%0d exp ov=0 win=00 p2=0", ov_b, win_b, p2_b);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0;
    cells_a = '0; cells_b = '0; cells_c = '0; cells_d = '0;
    test_reset();
    test_basic_w4();
    test_back_to_back();
    test_w6();
    test_conn_bounds();
    test_bad_cell();
    test_hold_and_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
